alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the 4-bit combinational ALU.
- Generalised to WIDTH bits and an 8-entry opcode set.
- Adds a valid/ready handshake on input and output, registered status flags (N, Z, C, V), and a multi-cycle shift-add multiplier.
- Sits between the controller datapath register file and the writeback stage; one operation is in flight at a time.

Parameters:
- WIDTH, 8, operand/result width in bits; legal values are 4 to 32.
- SHW, $clog2(WIDTH), derived; shift-amount width; not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and opcode valid
- in_ready  out  1  block can accept an operation
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B (shift amount in b[SHW-1:0])
- op  in  3  opcode (see Behaviour)
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer accepts the result
- result  out  WIDTH  registered result
- flags  out  4  {N,Z,C,V}, registered

Behaviour:
- Reset: one clock, clk; rst_n is asynchronous and active-low, applied on assertion, released synchronously by design convention. During reset: state=IDLE, out_valid=0, result=0, flags=0, multiplier cleared. in_ready=1 after release.
- Opcodes:
  - 0 AND: C=V=0.
  - 1 OR: C=V=0.
  - 2 ADD: a+b. C=carry out of the MSB. V=signed overflow.
  - 3 SUB: a-b. C=borrow (1 when a<b unsigned). V=signed overflow.
  - 4 XOR: C=V=0.
  - 5 SHL: a<<b[SHW-1:0]. C=last bit shifted out (0 if amount=0). V=0.
  - 6 SHR logical: a>>b[SHW-1:0]. C=last bit shifted out (0 if amount=0). V=0.
  - 7 MUL unsigned: low WIDTH bits of a*b. C=1 if upper WIDTH bits are nonzero. V=0.
- All ops: N=result[WIDTH-1], Z=(result==0). Upper bits of b above SHW are ignored for shifts.
- States:
  - IDLE: in_ready=1. On accept (in_valid && in_ready):
    - op!=MUL: compute combinationally, register result/flags, go to DONE.
    - op==MUL: latch a and b, go to BUSY.
  - BUSY: in_ready=0. One shift-add step per cycle with a WIDTH-cycle counter. After WIDTH steps, register result/flags and go to DONE.
  - DONE: out_valid=1.
    - out_ready=1: the result is consumed this cycle. in_ready=1 in the same cycle, so a new op can be accepted back-to-back (DONE->DONE or DONE->BUSY); otherwise go to IDLE.
    - out_ready=0: result and flags are held stable and in_ready=0.
- Latency from accept to out_valid: 1 cycle for single-cycle ops; WIDTH+1 cycles for MUL.
- Throughput: 1 op/cycle for single-cycle ops with out_ready tied high.
- Inputs a, b and op are sampled only on the accept cycle; later changes have no effect.
- in_valid while in_ready=0 is ignored, not queued. The producer holds the request.
- Reset asserted mid-BUSY or in DONE: the operation is discarded and out_valid drops immediately (asynchronously).
- Arithmetic is modular in WIDTH bits; carry and borrow are computed on a WIDTH+1 bit sum.

Decomposition:
- alu_pkg holds:
  - op_e enum: OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR, OP_SHL, OP_SHR, OP_MUL.
  - flags_t packed struct {n,z,c,v}.
  - state_e enum: IDLE, BUSY, DONE.
- Sub-module alu_mul_seq: sequential shift-add unsigned multiplier, WIDTH-parametrised, with start/done and a 2*WIDTH product. The top module owns the handshake and flag logic.

Test Plan (WIDTH=8):
- ADD a=0xF0, b=0x20 -> after 1 cycle: result=0x10, flags N=0 Z=0 C=1 V=0. SUB a=0x80, b=0x01 -> result=0x7F, C=0, V=1.
- SUB a=0x05, b=0x07 -> result=0xFE, N=1, C=1 (borrow). SHL a=0x81, b=0xF9 (amount 1) -> result=0x02, C=1.
- MUL a=0x0D, b=0x0B -> out_valid exactly 9 cycles after accept, result=0x8F, C=0, in_ready=0 throughout BUSY. MUL a=0x10, b=0x10 -> result=0x00, Z=1, C=1.
- Backpressure: complete an AND, hold out_ready=0 for 5 cycles while toggling a/b/op/in_valid -> result, flags and out_valid stable, in_ready=0; on out_ready=1, in_ready=1 in the same cycle.
- Back-to-back: out_ready=1, in_valid=1 for 4 consecutive ADDs (1+1, 2+2, 3+3, 4+4) -> results 0x02, 0x04, 0x06, 0x08 on consecutive cycles with no bubbles.
- Reset mid-MUL: assert rst_n=0 at BUSY cycle 4 -> out_valid=0 and result=0 immediately; after release, in_ready=1 and a fresh ADD 0x01+0x01 returns 0x02.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the registered ALU: opcodes, flag bundle, FSM states.
// Imported by alu_seq and alu_mul_seq.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add unsigned multiplier, one partial product per cycle.
// o_product is valid in the cycle o_done is high (final step).
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic [2*WIDTH-1:0] w_add;
  logic [2*WIDTH-1:0] w_acc_nxt;

  assign w_add     = r_mplier[0] ? r_mcand : '0;
  assign w_acc_nxt = r_acc + w_add;
  assign o_done    = r_busy && (r_cnt == LAST);
  assign o_product = w_acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_acc    <= '0;
      r_mplier <= i_b;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (o_done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with valid/ready handshake and N/Z/C/V flags.
// One op in flight; MUL runs on the sequential multiplier.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [WIDTH-1:0]   r_result;
  flags_t             r_flags;

  logic               w_rdy;
  logic               w_start;
  logic               w_ld_alu;
  logic               w_ld_mul;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_dif;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH:0]     w_shr;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;
  flags_t             w_alu_flg;
  flags_t             w_mul_flg;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_start),
    .i_a       (a),
    .i_b       (b),
    .o_done    (w_mul_done),
    .o_product (w_prod)
  );

  // Carry/borrow and shifted-out bits fall out of the extra top/bottom bit.
  always_comb begin
    w_sum = {1'b0, a} + {1'b0, b};
    w_dif = {1'b0, a} - {1'b0, b};
    w_shl = {1'b0, a} << b[SHW-1:0];
    w_shr = {a, 1'b0} >> b[SHW-1:0];
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    unique case (op_e'(op))
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[WIDTH-1] == b[WIDTH-1]) &&
                (w_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_dif[WIDTH-1:0];
        w_c   = w_dif[WIDTH];
        w_v   = (a[WIDTH-1] != b[WIDTH-1]) &&
                (w_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SHL: begin
        w_res = w_shl[WIDTH-1:0];
        w_c   = w_shl[WIDTH];
      end
      OP_SHR: begin
        w_res = w_shr[WIDTH:1];
        w_c   = w_shr[0];
      end
      OP_MUL: w_res = '0;
    endcase
    w_alu_flg.n = w_res[WIDTH-1];
    w_alu_flg.z = (w_res == '0);
    w_alu_flg.c = w_c;
    w_alu_flg.v = w_v;
    w_mul_flg.n = w_prod[WIDTH-1];
    w_mul_flg.z = (w_prod[WIDTH-1:0] == '0);
    w_mul_flg.c = |w_prod[2*WIDTH-1:WIDTH];
    w_mul_flg.v = 1'b0;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rdy       = 1'b0;
    w_start     = 1'b0;
    w_ld_alu    = 1'b0;
    w_ld_mul    = 1'b0;
    unique case (r_state)
      IDLE: w_rdy = 1'b1;
      BUSY: begin
        if (w_mul_done) begin
          w_ld_mul    = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_rdy = out_ready;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (in_valid && w_rdy) begin
      if (op_e'(op) == OP_MUL) begin
        w_start     = 1'b1;
        w_state_nxt = BUSY;
      end else begin
        w_ld_alu    = 1'b1;
        w_state_nxt = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ld_alu) begin
        r_result <= w_res;
        r_flags  <= w_alu_flg;
      end else if (w_ld_mul) begin
        r_result <= w_prod[WIDTH-1:0];
        r_flags  <= w_mul_flg;
      end
    end
  end

  assign in_ready  = w_rdy;
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign flags     = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed plan plus
// randomized ops against an integer reference model.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [3:0] flags;

  int checks   = 0;
  int failures = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns {N,Z,C,V,result} computed from plain integer arithmetic.
  function automatic logic [11:0] ref_op(input int o, input int x,
                                         input int y);
    int r, s, sx, sy, amt, c, v;
    logic [7:0] rb;
    logic [3:0] f;
    amt = y % 8;
    sx  = (x >= 128) ? x - 256 : x;
    sy  = (y >= 128) ? y - 256 : y;
    c = 0; v = 0; r = 0;
    case (o)
      0: r = x & y;
      1: r = x | y;
      2: begin
        s = x + y; r = s % 256; c = (s > 255) ? 1 : 0;
        v = ((sx + sy) > 127 || (sx + sy) < -128) ? 1 : 0;
      end
      3: begin
        s = x - y; r = (s + 256) % 256; c = (x < y) ? 1 : 0;
        v = ((sx - sy) > 127 || (sx - sy) < -128) ? 1 : 0;
      end
      4: r = x ^ y;
      5: begin
        r = (x * (1 << amt)) % 256;
        c = (amt == 0) ? 0 : ((x >> (8 - amt)) & 1);
      end
      6: begin
        r = x >> amt;
        c = (amt == 0) ? 0 : ((x >> (amt - 1)) & 1);
      end
      default: begin
        s = x * y; r = s % 256; c = (s > 255) ? 1 : 0;
      end
    endcase
    rb = 8'(r);
    f  = {rb[7], (r == 0), (c != 0), (v != 0)};
    return {f, rb};
  endfunction

  // Issue one op at the current (post-edge) time, scramble the inputs
  // after accept, wait for out_valid and check latency/result/flags.
  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] er, input logic [3:0] ef);
    int n;
    int busy_bad;
    int exp_lat;
    a = x; b = y; op = o; in_valid = 1'b1;
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
    n = 0;
    busy_bad = 0;
    while (!out_valid && n < 40) begin
      if (in_ready !== 1'b0) busy_bad++;
      @(posedge clk); #1;
      n++;
    end
    exp_lat = (o == 3'd7) ? 9 : 1;
    chk({tag, ".lat"}, 32'(n + 1), 32'(exp_lat));
    chk({tag, ".res"}, 32'(result), 32'(er));
    chk({tag, ".flg"}, 32'(flags), 32'(ef));
    if (o == 3'd7) chk({tag, ".busy_rdy"}, 32'(busy_bad), 32'd0);
  endtask

  initial begin
    logic [11:0] m;
    logic [7:0]  ra, rb2;
    logic [2:0]  ro;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.result", 32'(result), 32'd0);
    chk("rst.flags", 32'(flags), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Directed plan; flags are {N,Z,C,V}.
    run_op("add_f0_20", 3'd2, 8'hF0, 8'h20, 8'h10, 4'b0010);
    run_op("sub_80_01", 3'd3, 8'h80, 8'h01, 8'h7F, 4'b0001);
    run_op("sub_05_07", 3'd3, 8'h05, 8'h07, 8'hFE, 4'b1010);
    run_op("shl_81_f9", 3'd5, 8'h81, 8'hF9, 8'h02, 4'b0010);
    run_op("shr_81_00", 3'd6, 8'h81, 8'h00, 8'h81, 4'b1000);
    run_op("mul_0d_0b", 3'd7, 8'h0D, 8'h0B, 8'h8F, 4'b1000);
    run_op("mul_10_10", 3'd7, 8'h10, 8'h10, 8'h00, 4'b0110);
    @(posedge clk); #1;

    // Backpressure: result held while inputs toggle.
    out_ready = 1'b0;
    run_op("bp_and", 3'd0, 8'hCC, 8'hAA, 8'h88, 4'b1000);
    for (int i = 0; i < 5; i++) begin
      a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
      in_valid = 1'($urandom);
      #1;
      chk("bp.in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      chk("bp.out_valid", 32'(out_valid), 32'd1);
      chk("bp.result", 32'(result), 32'h88);
      chk("bp.flags", 32'(flags), 32'h8);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp.release_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp.drained", 32'(out_valid), 32'd0);

    // Back-to-back ADDs, one result per cycle.
    for (int i = 1; i <= 4; i++) begin
      a = 8'(i); b = 8'(i); op = 3'd2; in_valid = 1'b1;
      #1;
      chk("b2b.in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      chk("b2b.out_valid", 32'(out_valid), 32'd1);
      chk("b2b.result", 32'(result), 32'(2 * i));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b.idle", 32'(out_valid), 32'd0);

    // Reset at BUSY cycle 4 of a MUL.
    a = 8'h03; b = 8'h05; op = 3'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rmul.busy_rdy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rmul.out_valid", 32'(out_valid), 32'd0);
    chk("rmul.result", 32'(result), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rmul.in_ready", 32'(in_ready), 32'd1);
    run_op("rmul_add", 3'd2, 8'h01, 8'h01, 8'h02, 4'b0000);
    @(posedge clk); #1;

    // Reset while a result is waiting in DONE.
    out_ready = 1'b0;
    run_op("rdone_add", 3'd2, 8'h7F, 8'h01, 8'h80, 4'b1001);
    rst_n = 1'b0;
    #1;
    chk("rdone.out_valid", 32'(out_valid), 32'd0);
    chk("rdone.flags", 32'(flags), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;

    // Randomized ops against the reference model.
    for (int i = 0; i < 60; i++) begin
      ra  = 8'($urandom);
      rb2 = 8'($urandom);
      ro  = 3'($urandom);
      m   = ref_op(int'(ro), int'(ra), int'(rb2));
      run_op($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb2,
             m[7:0], m[11:8]);
    end

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
